// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard/stall controller: FSM encoding,
// register-field width, stall lengths and the source-register match helper.
package hazard_pkg;

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] STALL    = 2'd1;
   localparam logic [1:0] MEM_WAIT = 2'd2;

   localparam int REG_W = 5;

   localparam logic [1:0] LOAD_USE_STALLS    = 2'd1;
   localparam logic [1:0] BRANCH_LOAD_STALLS = 2'd2;

   // $zero never carries a dependency; rt only counts when the ID instruction reads it
   function automatic logic srcMatch(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             usesRt);
      return (dst != '0) && ((dst == rs) || (usesRt && (dst == rt)));
   endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side signal bundle of the hazard controller: ID/EX/MEM fields and
// flags toward the controller, stall/flush/freeze controls back to the datapath.
interface hazard_stall_controller_if;
   import hazard_pkg::*;

   logic [REG_W-1:0] ID_rs;
   logic [REG_W-1:0] ID_rt;
   logic             ID_UsesRt;
   logic             ID_Branch;
   logic             BranchTaken;
   logic             EX_MemRead;
   logic             EX_RegWrite;
   logic [REG_W-1:0] EX_WriteReg;
   logic             MEM_MemRead;
   logic [REG_W-1:0] MEM_WriteReg;
   logic             MemReq;
   logic             MemReady;

   logic             PCWrite;
   logic             IFIDWrite;
   logic             IDEXBubble;
   logic             IFIDFlush;
   logic             PipeFreeze;
   logic             MemTimeout;

   modport master (
      output ID_rs, ID_rt, ID_UsesRt, ID_Branch, BranchTaken,
             EX_MemRead, EX_RegWrite, EX_WriteReg, MEM_MemRead, MEM_WriteReg,
             MemReq, MemReady,
      input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze, MemTimeout
   );

   modport slave (
      input  ID_rs, ID_rt, ID_UsesRt, ID_Branch, BranchTaken,
             EX_MemRead, EX_RegWrite, EX_WriteReg, MEM_MemRead, MEM_WriteReg,
             MemReq, MemReady,
      output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze, MemTimeout
   );

endinterface

// File: rtl/hazard_detect.sv
// Combinational hazard classifier: decides whether the ID instruction must
// stall and for how many cycles, given the EX and MEM destination registers.
module hazard_detect
   import hazard_pkg::*;
(
   input  logic [REG_W-1:0] idRs,
   input  logic [REG_W-1:0] idRt,
   input  logic             idUsesRt,
   input  logic             idBranch,
   input  logic             exMemRead,
   input  logic             exRegWrite,
   input  logic [REG_W-1:0] exWriteReg,
   input  logic             memMemRead,
   input  logic [REG_W-1:0] memWriteReg,
   output logic             hazard,
   output logic [1:0]       stallCnt
);

   logic exMatch;
   logic memMatch;

   always_comb begin
      exMatch  = srcMatch(exWriteReg, idRs, idRt, idUsesRt);
      memMatch = srcMatch(memWriteReg, idRs, idRt, idUsesRt);
      stallCnt = 2'd0;
      // a branch behind a load in EX waits for the load to clear MEM
      if (idBranch && exMemRead && exMatch)
         stallCnt = BRANCH_LOAD_STALLS;
      else if ((exMemRead && exMatch) ||
               (idBranch && exRegWrite && !exMemRead && exMatch) ||
               (idBranch && memMemRead && memMatch))
         stallCnt = LOAD_USE_STALLS;
   end

   assign hazard = (stallCnt != 2'd0);

endmodule

// File: rtl/hazard_stall_controller.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use and branch stalls,
// taken-branch flush, memory-wait freeze with timeout. Define HAZARD_PERF_CNT_EN
// to add saturating StallCycles/FlushCount/FreezeCycles counters.
module hazard_stall_controller
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 5
) (
   input  logic                      Clk,
   input  logic                      Reset,
   hazard_stall_controller_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]               StallCycles,
   output logic [31:0]               FlushCount,
   output logic [31:0]               FreezeCycles
`endif
);

   logic [1:0]      state, nextState;
   logic [1:0]      retState, nextRetState;
   logic [1:0]      stallCnt, nextStallCnt;
   logic [1:0]      detCnt;
   logic [TO_W-1:0] timeoutCnt, nextTimeoutCnt;
   logic            memTimeoutQ, nextMemTimeout;
   logic            hazard, memMiss, timeoutHit;
   logic            pcWrite, ifidWrite, bubble, flush, freeze;

   hazard_detect uDetect (
      .idRs        (hz.ID_rs),
      .idRt        (hz.ID_rt),
      .idUsesRt    (hz.ID_UsesRt),
      .idBranch    (hz.ID_Branch),
      .exMemRead   (hz.EX_MemRead),
      .exRegWrite  (hz.EX_RegWrite),
      .exWriteReg  (hz.EX_WriteReg),
      .memMemRead  (hz.MEM_MemRead),
      .memWriteReg (hz.MEM_WriteReg),
      .hazard      (hazard),
      .stallCnt    (detCnt)
   );

   assign memMiss    = hz.MemReq && !hz.MemReady;
   assign timeoutHit = (timeoutCnt == TO_W'(MEM_TIMEOUT - 1));

   always_comb begin
      nextState      = state;
      nextRetState   = retState;
      nextStallCnt   = stallCnt;
      nextTimeoutCnt = timeoutCnt;
      nextMemTimeout = memTimeoutQ;
      pcWrite        = 1'b1;
      ifidWrite      = 1'b1;
      bubble         = 1'b0;
      flush          = 1'b0;
      freeze         = 1'b0;
      case (state)
         RUN: begin
            if (memMiss) begin
               freeze         = 1'b1;
               pcWrite        = 1'b0;
               ifidWrite      = 1'b0;
               nextState      = MEM_WAIT;
               nextRetState   = RUN;
               nextTimeoutCnt = '0;
            end else if (hazard) begin
               pcWrite   = 1'b0;
               ifidWrite = 1'b0;
               bubble    = 1'b1;
               if (detCnt == BRANCH_LOAD_STALLS) begin
                  nextStallCnt = detCnt - 2'd1;
                  nextState    = STALL;
               end
            end else if (hz.ID_Branch && hz.BranchTaken) begin
               flush = 1'b1;
            end
         end
         STALL: begin
            if (memMiss) begin
               freeze         = 1'b1;
               pcWrite        = 1'b0;
               ifidWrite      = 1'b0;
               nextState      = MEM_WAIT;
               nextRetState   = STALL;
               nextTimeoutCnt = '0;
            end else begin
               // branch operands are still in flight, so BranchTaken is not trusted here
               pcWrite      = 1'b0;
               ifidWrite    = 1'b0;
               bubble       = 1'b1;
               nextStallCnt = (stallCnt == 2'd0) ? 2'd0 : stallCnt - 2'd1;
               if (stallCnt <= 2'd1)
                  nextState = RUN;
            end
         end
         MEM_WAIT: begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            freeze    = !hz.MemReady;
            if (hz.MemReady) begin
               nextState = retState;
            end else if (timeoutHit) begin
               nextState      = RUN;
               nextStallCnt   = 2'd0;
               nextMemTimeout = 1'b1;
            end else begin
               nextTimeoutCnt = timeoutCnt + 1'b1;
            end
         end
         default: nextState = RUN;
      endcase
      // reset values must show immediately, not only after the registers settle
      if (!Reset) begin
         pcWrite   = 1'b1;
         ifidWrite = 1'b1;
         bubble    = 1'b0;
         flush     = 1'b0;
         freeze    = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state       <= RUN;
         retState    <= RUN;
         stallCnt    <= 2'd0;
         timeoutCnt  <= '0;
         memTimeoutQ <= 1'b0;
      end else begin
         state       <= nextState;
         retState    <= nextRetState;
         stallCnt    <= nextStallCnt;
         timeoutCnt  <= nextTimeoutCnt;
         memTimeoutQ <= nextMemTimeout;
      end
   end

   assign hz.PCWrite    = pcWrite;
   assign hz.IFIDWrite  = ifidWrite;
   assign hz.IDEXBubble = bubble;
   assign hz.IFIDFlush  = flush;
   assign hz.PipeFreeze = freeze;
   assign hz.MemTimeout = memTimeoutQ;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         StallCycles  <= '0;
         FlushCount   <= '0;
         FreezeCycles <= '0;
      end else begin
         if (bubble && (StallCycles != '1))
            StallCycles <= StallCycles + 32'd1;
         if (flush && (FlushCount != '1))
            FlushCount <= FlushCount + 32'd1;
         if (freeze && (FreezeCycles != '1))
            FreezeCycles <= FreezeCycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed and randomized checks of hazard_stall_controller against a
// cycle-level behavioural model of the stall/flush/freeze rules.
module tb_hazard_stall_controller;
   import hazard_pkg::*;

   localparam int MEM_TIMEOUT = 16;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   hazard_stall_controller_if hz ();

   hazard_stall_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(5)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .hz    (hz)
   );

   always #5 Clk = ~Clk;

   // reference model: remaining stall cycles, outstanding memory wait, sticky timeout
   int stallsLeft;
   int resumeStalls;
   int waitCycles;
   bit waiting;
   bit timedOut;

   function automatic logic [5:0] obsVec();
      return {hz.PCWrite, hz.IFIDWrite, hz.IDEXBubble, hz.IFIDFlush, hz.PipeFreeze, hz.MemTimeout};
   endfunction

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   function automatic int neededStalls();
      bit exHit, memHit;
      int n = 0;
      exHit  = (hz.EX_WriteReg != 0) &&
               ((hz.EX_WriteReg == hz.ID_rs) || (hz.ID_UsesRt && (hz.EX_WriteReg == hz.ID_rt)));
      memHit = (hz.MEM_WriteReg != 0) &&
               ((hz.MEM_WriteReg == hz.ID_rs) || (hz.ID_UsesRt && (hz.MEM_WriteReg == hz.ID_rt)));
      if (hz.EX_MemRead && exHit)
         n = hz.ID_Branch ? 2 : 1;
      else if (hz.ID_Branch && ((hz.EX_RegWrite && exHit) || (hz.MEM_MemRead && memHit)))
         n = 1;
      return n;
   endfunction

   task automatic modelReset();
      stallsLeft   = 0;
      resumeStalls = 0;
      waitCycles   = 0;
      waiting      = 0;
      timedOut     = 0;
   endtask

   task automatic idle();
      hz.ID_rs        = 5'd1;
      hz.ID_rt        = 5'd2;
      hz.ID_UsesRt    = 1'b0;
      hz.ID_Branch    = 1'b0;
      hz.BranchTaken  = 1'b0;
      hz.EX_MemRead   = 1'b0;
      hz.EX_RegWrite  = 1'b0;
      hz.EX_WriteReg  = 5'd0;
      hz.MEM_MemRead  = 1'b0;
      hz.MEM_WriteReg = 5'd0;
      hz.MemReq       = 1'b0;
      hz.MemReady     = 1'b1;
   endtask

   // one clock: check this cycle's outputs against the model, then advance the model
   task automatic step(input string tag);
      logic [5:0] exp;
      int n;
      bit miss;
      @(negedge Clk);
      n    = neededStalls();
      miss = hz.MemReq && !hz.MemReady;
      exp  = {5'b11000, timedOut};
      if (waiting) begin
         exp[5:1] = {4'b0000, !hz.MemReady};
         if (hz.MemReady) begin
            waiting    = 0;
            stallsLeft = resumeStalls;
         end else begin
            waitCycles++;
            if (waitCycles == MEM_TIMEOUT) begin
               waiting    = 0;
               timedOut   = 1;
               stallsLeft = 0;
            end
         end
      end else if (miss) begin
         exp[5:1]     = 5'b00001;
         waiting      = 1;
         waitCycles   = 0;
         resumeStalls = stallsLeft;
      end else if (stallsLeft > 0) begin
         exp[5:1] = 5'b00100;
         stallsLeft--;
      end else if (n > 0) begin
         exp[5:1]   = 5'b00100;
         stallsLeft = n - 1;
      end else if (hz.ID_Branch && hz.BranchTaken) begin
         exp[5:1] = 5'b11010;
      end
      check(tag, obsVec(), exp);
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [4:0] randReg();
      case ($urandom_range(0, 3))
         0:       return 5'd0;
         1:       return 5'd8;
         2:       return 5'd9;
         default: return 5'd10;
      endcase
   endfunction

   initial begin
      idle();
      modelReset();
      #1 Reset = 1'b0;
      #10;
      check("resetOut", obsVec(), 6'b110000);
      check("resetState", {4'b0, dut.state}, {4'b0, RUN});
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1;

      // load-use, rt gating, $zero
      hz.EX_MemRead = 1'b1; hz.EX_RegWrite = 1'b1; hz.EX_WriteReg = 5'd8; hz.ID_rs = 5'd8;
      step("loadUse");
      idle();
      step("afterLoadUse");
      hz.EX_MemRead = 1'b1; hz.EX_WriteReg = 5'd8; hz.ID_rs = 5'd3; hz.ID_rt = 5'd8;
      step("rtUnused");
      hz.ID_UsesRt = 1'b1;
      step("rtUsed");
      idle();
      hz.EX_MemRead = 1'b1; hz.EX_WriteReg = 5'd0; hz.ID_rs = 5'd0;
      step("regZero");

      // branch behind a load in EX: two bubbles, taken flag ignored while stalled
      idle();
      hz.ID_Branch = 1'b1; hz.BranchTaken = 1'b1;
      hz.EX_MemRead = 1'b1; hz.EX_RegWrite = 1'b1; hz.EX_WriteReg = 5'd9; hz.ID_rs = 5'd9;
      step("brLoadEx1");
      check("brLoadExState", {4'b0, dut.state}, {4'b0, STALL});
      hz.EX_MemRead = 1'b0; hz.EX_RegWrite = 1'b0; hz.MEM_MemRead = 1'b1; hz.MEM_WriteReg = 5'd9;
      step("brLoadEx2");
      check("brLoadExBack", {4'b0, dut.state}, {4'b0, RUN});
      hz.MEM_MemRead = 1'b0; hz.MEM_WriteReg = 5'd0;
      step("brFlush");
      idle();
      step("flushOnce");

      // branch behind ALU op in EX, behind load in MEM; plain op behind MEM load
      hz.ID_Branch = 1'b1; hz.EX_RegWrite = 1'b1; hz.EX_WriteReg = 5'd10;
      hz.ID_UsesRt = 1'b1; hz.ID_rt = 5'd10;
      step("brAlu");
      idle();
      hz.ID_Branch = 1'b1; hz.MEM_MemRead = 1'b1; hz.MEM_WriteReg = 5'd11; hz.ID_rs = 5'd11;
      step("brLoadMem");
      hz.ID_Branch = 1'b0;
      step("aluLoadMem");

      // four-cycle memory wait
      idle();
      hz.MemReq = 1'b1; hz.MemReady = 1'b0;
      for (int i = 0; i < 4; i++) step("memWait");
      hz.MemReady = 1'b1;
      step("memReady");
      idle();
      step("memDone");

      // memory miss during STALL keeps the remaining stall
      hz.ID_Branch = 1'b1;
      hz.EX_MemRead = 1'b1; hz.EX_WriteReg = 5'd9; hz.ID_rs = 5'd9;
      step("stallEnter");
      hz.EX_MemRead = 1'b0; hz.MemReq = 1'b1; hz.MemReady = 1'b0;
      step("stallMiss");
      step("stallWait");
      hz.MemReady = 1'b1;
      step("stallResume");
      hz.MemReq = 1'b0;
      step("stallTail");
      step("stallExit");

      // timeout after MEM_TIMEOUT wait cycles, sticky afterwards
      idle();
      hz.MemReq = 1'b1; hz.MemReady = 1'b0;
      for (int i = 0; i < MEM_TIMEOUT + 1; i++) step("timeoutWait");
      idle();
      step("afterTimeout");
      check("timeoutState", {4'b0, dut.state}, {4'b0, RUN});
      step("timeoutSticky");

      // asynchronous reset in the middle of a stall
      hz.ID_Branch = 1'b1;
      hz.EX_MemRead = 1'b1; hz.EX_WriteReg = 5'd9; hz.ID_rs = 5'd9;
      step("preResetStall");
      #1 Reset = 1'b0;
      #1;
      check("midStallReset", obsVec(), 6'b110000);
      check("midStallResetState", {4'b0, dut.state}, {4'b0, RUN});
      modelReset();
      @(negedge Clk);
      Reset = 1'b1;
      idle();
      @(posedge Clk);
      #1;

      for (int i = 0; i < 3000; i++) begin
         hz.ID_rs        = randReg();
         hz.ID_rt        = randReg();
         hz.ID_UsesRt    = 1'($urandom_range(0, 1));
         hz.ID_Branch    = 1'($urandom_range(0, 1));
         hz.BranchTaken  = 1'($urandom_range(0, 1));
         hz.EX_MemRead   = 1'($urandom_range(0, 1));
         hz.EX_RegWrite  = 1'($urandom_range(0, 1));
         hz.EX_WriteReg  = randReg();
         hz.MEM_MemRead  = 1'($urandom_range(0, 1));
         hz.MEM_WriteReg = randReg();
         hz.MemReq       = ($urandom_range(0, 3) == 0);
         hz.MemReady     = ($urandom_range(0, 2) != 0);
         step("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline hazard controller for the 5-stage MIPS datapath; it works alongside the EX-stage forwarding unit.
- Detects hazards the forwarding paths cannot cover and sequences the required stalls, bubbles and flushes:
  - load-use hazards;
  - branch-operand dependencies, since branches resolve in ID;
  - data-memory wait states.
- Drives PC/IF-ID write enables, the ID/EX bubble, the IF/ID flush and a whole-pipe freeze.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before the timeout error.
- TO_W, 5: timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- Clk  input  1  pipeline clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- ID_rs  input  5  rs field of the instruction in ID.
- ID_rt  input  5  rt field of the instruction in ID.
- ID_UsesRt  input  1  ID instruction reads rt.
- ID_Branch  input  1  ID instruction is a branch (resolved in ID).
- BranchTaken  input  1  ID branch comparison result.
- EX_MemRead  input  1  EX instruction is a load.
- EX_RegWrite  input  1  EX instruction writes a register.
- EX_WriteReg  input  5  destination register of the EX instruction.
- MEM_MemRead  input  1  MEM instruction is a load.
- MEM_WriteReg  input  5  destination register of the MEM instruction.
- MemReq  input  1  MEM stage is accessing data memory.
- MemReady  input  1  data memory completes the access this cycle.
- PCWrite  output  1  PC update enable.
- IFIDWrite  output  1  IF/ID register write enable.
- IDEXBubble  output  1  zero the ID/EX control fields.
- IFIDFlush  output  1  clear the IF/ID instruction.
- PipeFreeze  output  1  hold every pipeline register (memory wait).
- MemTimeout  output  1  sticky error flag.

Behaviour:
- Register 0 never creates a hazard. The rt comparison counts only when ID_UsesRt=1 (rs is always compared).
- Hazard cases in RUN state:
  - Load-use: EX_MemRead=1 and EX_WriteReg matches an ID source. Stall 1 cycle.
  - Branch after ALU: ID_Branch=1, EX_RegWrite=1, EX_MemRead=0 and EX_WriteReg matches. Stall 1 cycle.
  - Branch after load in EX: ID_Branch=1, EX_MemRead=1, match. Stall 2 cycles.
  - Branch after load in MEM: ID_Branch=1, MEM_MemRead=1, MEM_WriteReg matches. Stall 1 cycle.
- Stall outputs are combinational in the detecting cycle: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
- FSM states are RUN, STALL, MEM_WAIT. StallCnt is 2 bits.
- RUN:
  - MemReq=1 and MemReady=0: PipeFreeze=1, PCWrite=0, IFIDWrite=0, no bubble. Next state MEM_WAIT; clear TimeoutCnt.
  - Otherwise, a hazard needing N stalls: assert stall outputs; if N=2, load StallCnt=1 and go to STALL, else stay in RUN.
  - Otherwise, ID_Branch=1 and BranchTaken=1: IFIDFlush=1 for one cycle; PCWrite=1.
  - Otherwise all enables are 1 and the strobes are 0.
- STALL: assert the stall outputs and decrement StallCnt; at 0 return to RUN. While stalled, BranchTaken is ignored (its operands are not valid yet). A new MemReq miss in STALL takes priority: go to MEM_WAIT and retain StallCnt.
- MEM_WAIT:
  - PipeFreeze=1, PCWrite=0, IFIDWrite=0, IDEXBubble=0, IFIDFlush=0; TimeoutCnt increments.
  - MemReady=1: return to the pre-wait state (RUN, or STALL with the retained StallCnt). The freeze drops in that same cycle.
  - TimeoutCnt reaches MEM_TIMEOUT-1 without MemReady: set MemTimeout (sticky until reset) and return to RUN.
- Priority, highest first: memory wait, then data/branch stall, then branch flush.
- Reset asserted at any time, including mid-stall or mid-wait:
  - state returns to RUN; StallCnt and TimeoutCnt are cleared;
  - outputs: PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0, PipeFreeze=0, MemTimeout=0.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds three 32-bit output ports, saturating and cleared by reset:
  - StallCycles: counts cycles with IDEXBubble=1;
  - FlushCount: counts IFIDFlush pulses;
  - FreezeCycles: counts cycles with PipeFreeze=1.
- When undefined, these ports and their counters do not exist.

Decomposition:
- Package hazard_pkg holds:
  - state encoding: RUN=2'd0, STALL=2'd1, MEM_WAIT=2'd2;
  - REG_W=5;
  - the stall-count constants LOAD_USE_STALLS=1 and BRANCH_LOAD_STALLS=2.
- One natural combinational sub-module, hazard_detect. It takes the ID/EX/MEM register fields and flags and outputs hazard (1 bit) and stall count (2 bits).

Test Plan:
- lw $t0 in EX (EX_MemRead=1, EX_WriteReg=8); ID add with rs=8 -> one cycle with PCWrite=0, IFIDWrite=0, IDEXBubble=1; next cycle all enables=1.
- lw $t1 in EX (EX_WriteReg=9); ID beq with rs=9 -> two consecutive bubble cycles (RUN then STALL); state back to RUN on the third cycle.
- ID beq with BranchTaken=1, no hazard -> IFIDFlush=1 for exactly one cycle, PCWrite=1.
- MemReq=1, MemReady low for 4 cycles then high -> PipeFreeze=1 for 4 cycles, 0 on the ready cycle; MemTimeout stays 0.
- MemReq=1 with MemReady held low for 16 cycles -> MemTimeout=1 after cycle 16, stays set; FSM back in RUN.
- Deassert-then-assert Reset (drive low) mid-STALL -> outputs return to reset values immediately; state=RUN.
